// File: rtl/bitstream_packer.sv
// bitstream_packer: expands flag-coded encoder lanes into a handshaked byte stream behind a command FIFO.
module bitstream_packer #(
  parameter int BP_BITSTREAM_WIDTH = 8,
  parameter int BP_FIFO_DEPTH      = 4,
  parameter int BP_COUNT_WIDTH     = 32
) (
  input  logic                          top_clk,
  input  logic                          top_reset,
  input  logic                          in_valid,
  input  logic [2:0]                    in_flag_1,
  input  logic [2:0]                    in_flag_2,
  input  logic [2:0]                    in_flag_3,
  input  logic [BP_BITSTREAM_WIDTH-1:0] in_bit_1_1,
  input  logic [BP_BITSTREAM_WIDTH-1:0] in_bit_1_2,
  input  logic [BP_BITSTREAM_WIDTH-1:0] in_bit_1_3,
  input  logic [BP_BITSTREAM_WIDTH-1:0] in_bit_1_4,
  input  logic [BP_BITSTREAM_WIDTH-1:0] in_bit_1_5,
  input  logic [BP_BITSTREAM_WIDTH-1:0] in_bit_2_1,
  input  logic [BP_BITSTREAM_WIDTH-1:0] in_bit_2_2,
  input  logic [BP_BITSTREAM_WIDTH-1:0] in_bit_2_3,
  input  logic [BP_BITSTREAM_WIDTH-1:0] in_bit_2_4,
  input  logic [BP_BITSTREAM_WIDTH-1:0] in_bit_2_5,
  input  logic [BP_BITSTREAM_WIDTH-1:0] in_bit_3_1,
  input  logic [BP_BITSTREAM_WIDTH-1:0] in_bit_3_2,
  input  logic [BP_BITSTREAM_WIDTH-1:0] in_bit_3_3,
  input  logic [BP_BITSTREAM_WIDTH-1:0] in_bit_3_4,
  input  logic [BP_BITSTREAM_WIDTH-1:0] in_bit_3_5,
  input  logic                          in_flag_last,
  output logic                          in_ready,
  output logic [BP_BITSTREAM_WIDTH-1:0] out_byte,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic                          out_frame_done,
  output logic [BP_COUNT_WIDTH-1:0]     out_byte_count,
  output logic                          out_err_flag,
  output logic                          out_err_overflow
);
  localparam int W  = BP_BITSTREAM_WIDTH;
  localparam int AW = $clog2(BP_FIFO_DEPTH);
  localparam int EW = 15 * W + 10;
  typedef enum logic [2:0] {IDLE, LOAD, EMIT_HEAD, EMIT_RUN, EMIT_TAIL4, EMIT_TAIL5, NEXT_LANE, FRAME_END} state_t;
  state_t state, nxt;
  logic [EW-1:0] mem [BP_FIFO_DEPTH];
  logic [AW:0] wp, rp;
  logic [EW-1:0] in_word, head;
  logic full, empty, wr, pop, acc;
  logic [2:0] head_f1, fl, nfl;
  logic [W-1:0] head_b3;
  logic cur_last;
  logic [2:0][2:0] cur_flag;
  logic [2:0][4:0][W-1:0] cur_bytes;
  logic [1:0] lane, nl;
  logic [2:0] idx;
  logic [W-1:0] run;
  function automatic logic has_bytes(input logic [2:0] f);
    return f != 3'd0 && f != 3'd4;
  endfunction
  assign in_word = {in_flag_last, in_flag_3, in_flag_2, in_flag_1,
                    in_bit_3_5, in_bit_3_4, in_bit_3_3, in_bit_3_2, in_bit_3_1,
                    in_bit_2_5, in_bit_2_4, in_bit_2_3, in_bit_2_2, in_bit_2_1,
                    in_bit_1_5, in_bit_1_4, in_bit_1_3, in_bit_1_2, in_bit_1_1};
  assign empty = wp == rp;
  assign full = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign in_ready = !full;
  assign wr = in_valid && !full && (in_flag_last || in_flag_1 != 3'd0 || in_flag_2 != 3'd0 || in_flag_3 != 3'd0);
  assign head = mem[rp[AW-1:0]];
  assign head_f1 = head[15*W +: 3];
  assign head_b3 = head[2*W +: W];
  assign fl = cur_flag[lane];
  assign nl = lane + 2'd1;
  assign nfl = cur_flag[nl];
  assign out_valid = state inside {EMIT_HEAD, EMIT_RUN, EMIT_TAIL4, EMIT_TAIL5};
  assign acc = out_valid && out_ready;
  assign out_frame_done = state == FRAME_END;
  always_comb
    out_byte = state == EMIT_HEAD  ? cur_bytes[lane][idx] :
               state == EMIT_RUN   ? cur_bytes[lane][1] :
               state == EMIT_TAIL4 ? cur_bytes[lane][3] :
               state == EMIT_TAIL5 ? cur_bytes[lane][4] : '0;
  always_comb begin
    nxt = state;
    pop = 1'b0;
    case (state)
      IDLE:       nxt = (!empty || wr) ? LOAD : IDLE;
      LOAD: begin
        pop = 1'b1;
        nxt = has_bytes(head_f1) ? EMIT_HEAD : NEXT_LANE;
      end
      EMIT_HEAD:  if (acc) nxt = !fl[2] ? (idx == fl - 3'd1 ? NEXT_LANE : EMIT_HEAD) :
                                 run != '0 ? EMIT_RUN : fl != 3'd5 ? EMIT_TAIL4 : NEXT_LANE;
      EMIT_RUN:   if (acc && run == W'(1)) nxt = fl != 3'd5 ? EMIT_TAIL4 : NEXT_LANE;
      EMIT_TAIL4: if (acc) nxt = fl == 3'd7 ? EMIT_TAIL5 : NEXT_LANE;
      EMIT_TAIL5: if (acc) nxt = NEXT_LANE;
      NEXT_LANE:  nxt = lane != 2'd2 ? (has_bytes(nfl) ? EMIT_HEAD : NEXT_LANE) :
                        cur_last ? FRAME_END : !empty ? LOAD : IDLE;
      FRAME_END:  nxt = !empty ? LOAD : IDLE;
      default:    nxt = IDLE;
    endcase
  end
  always_ff @(posedge top_clk)
    if (wr) mem[wp[AW-1:0]] <= in_word;
  always_ff @(posedge top_clk or posedge top_reset)
    if (top_reset) begin
      state <= IDLE;
      wp <= '0;
      rp <= '0;
      cur_last <= 1'b0;
      cur_flag <= '0;
      cur_bytes <= '0;
      lane <= '0;
      idx <= '0;
      run <= '0;
      out_byte_count <= '0;
      out_err_flag <= 1'b0;
      out_err_overflow <= 1'b0;
    end else begin
      state <= nxt;
      wp <= wp + (AW+1)'(wr);
      rp <= rp + (AW+1)'(pop);
      out_err_overflow <= out_err_overflow || (in_valid && full);
      out_byte_count <= out_frame_done ? '0 : out_byte_count + BP_COUNT_WIDTH'(acc);
      if (state == LOAD) begin
        {cur_last, cur_flag, cur_bytes} <= head;
        lane <= '0;
        idx <= '0;
        run <= head_b3;
        out_err_flag <= out_err_flag || head_f1 == 3'd4;
      end else if (state == NEXT_LANE && lane != 2'd2) begin
        lane <= nl;
        idx <= '0;
        run <= cur_bytes[nl][2];
        out_err_flag <= out_err_flag || nfl == 3'd4;
      end
      if (state == EMIT_HEAD && acc) idx <= idx + 3'd1;
      if (state == EMIT_RUN && acc) run <= run - W'(1);
    end
endmodule

// File: tb/tb_bitstream_packer.sv
// tb_bitstream_packer: directed stimulus with a queue scoreboard checked by an independent output monitor.
module tb_bitstream_packer;
  logic top_clk = 1'b0, top_reset = 1'b1;
  logic in_valid = 1'b0, in_flag_last = 1'b0, out_ready = 1'b1;
  logic [2:0] in_flag_1 = '0, in_flag_2 = '0, in_flag_3 = '0;
  logic [7:0] in_bit_1_1, in_bit_1_2, in_bit_1_3, in_bit_1_4, in_bit_1_5;
  logic [7:0] in_bit_2_1, in_bit_2_2, in_bit_2_3, in_bit_2_4, in_bit_2_5;
  logic [7:0] in_bit_3_1, in_bit_3_2, in_bit_3_3, in_bit_3_4, in_bit_3_5;
  logic in_ready, out_valid, out_frame_done, out_err_flag, out_err_overflow;
  logic [7:0] out_byte;
  logic [31:0] out_byte_count;
  int checks = 0, failures = 0;
  logic [8:0] exp_q[$];
  localparam logic [8:0] DONE = 9'h100;

  bitstream_packer dut (
    .top_clk(top_clk), .top_reset(top_reset), .in_valid(in_valid),
    .in_flag_1(in_flag_1), .in_flag_2(in_flag_2), .in_flag_3(in_flag_3),
    .in_bit_1_1(in_bit_1_1), .in_bit_1_2(in_bit_1_2), .in_bit_1_3(in_bit_1_3), .in_bit_1_4(in_bit_1_4), .in_bit_1_5(in_bit_1_5),
    .in_bit_2_1(in_bit_2_1), .in_bit_2_2(in_bit_2_2), .in_bit_2_3(in_bit_2_3), .in_bit_2_4(in_bit_2_4), .in_bit_2_5(in_bit_2_5),
    .in_bit_3_1(in_bit_3_1), .in_bit_3_2(in_bit_3_2), .in_bit_3_3(in_bit_3_3), .in_bit_3_4(in_bit_3_4), .in_bit_3_5(in_bit_3_5),
    .in_flag_last(in_flag_last), .in_ready(in_ready), .out_byte(out_byte), .out_valid(out_valid),
    .out_ready(out_ready), .out_frame_done(out_frame_done), .out_byte_count(out_byte_count),
    .out_err_flag(out_err_flag), .out_err_overflow(out_err_overflow)
  );

  always #5 top_clk = ~top_clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] want);
    checks++;
    if (act !== want) begin
      failures++;
      $display("FAIL %s got=%0h want=%0h", name, act, want);
    end
  endtask

  task automatic mon_pop(input string name, input logic [8:0] got);
    logic [8:0] w;
    if (exp_q.size() == 0) begin
      checks++;
      failures++;
      $display("FAIL %s unexpected got=%0h want=none", name, got);
    end else begin
      w = exp_q.pop_front();
      chk(name, 32'(got), 32'(w));
    end
  endtask

  always @(negedge top_clk)
    if (!top_reset) begin
      if (out_valid && out_ready) mon_pop("mon_byte", {1'b0, out_byte});
      if (out_frame_done) mon_pop("mon_frame_done", DONE);
    end

  // lane vectors are {b5,b4,b3,b2,b1}
  task automatic drive(input logic [2:0] f1, input logic [39:0] l1, input logic [2:0] f2, input logic [39:0] l2,
                       input logic [2:0] f3, input logic [39:0] l3, input logic last);
    in_valid = 1'b1;
    in_flag_1 = f1;
    in_flag_2 = f2;
    in_flag_3 = f3;
    in_flag_last = last;
    {in_bit_1_5, in_bit_1_4, in_bit_1_3, in_bit_1_2, in_bit_1_1} = l1;
    {in_bit_2_5, in_bit_2_4, in_bit_2_3, in_bit_2_2, in_bit_2_1} = l2;
    {in_bit_3_5, in_bit_3_4, in_bit_3_3, in_bit_3_2, in_bit_3_1} = l3;
  endtask

  task automatic send(input logic [2:0] f1, input logic [39:0] l1, input logic [2:0] f2, input logic [39:0] l2,
                      input logic [2:0] f3, input logic [39:0] l3, input logic last);
    drive(f1, l1, f2, l2, f3, l3, last);
    @(posedge top_clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic drain(input string name);
    for (int i = 0; i < 600 && exp_q.size() != 0; i++) @(posedge top_clk);
    chk(name, exp_q.size(), 0);
    repeat (6) @(posedge top_clk);
    #1;
  endtask

  initial begin
    drive(3'd0, '0, 3'd0, '0, 3'd0, '0, 1'b0);
    in_valid = 1'b0;
    repeat (2) @(posedge top_clk);
    #1;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_byte", out_byte, 0);
    chk("rst_frame_done", out_frame_done, 0);
    chk("rst_count", out_byte_count, 0);
    chk("rst_errs", {out_err_flag, out_err_overflow}, 0);
    top_reset = 1'b0;
    @(posedge top_clk);
    #1;
    // literal lane: latency and back-to-back bytes
    exp_q.push_back(9'h11); exp_q.push_back(9'h22); exp_q.push_back(9'h33);
    drive(3'd3, {8'h00, 8'h00, 8'h33, 8'h22, 8'h11}, 3'd0, '0, 3'd0, '0, 1'b0);
    @(posedge top_clk);
    #1 in_valid = 1'b0;
    chk("lat_t1_valid", out_valid, 0);
    @(posedge top_clk); #1;
    chk("lat_t2_valid", out_valid, 1);
    chk("lat_t2_byte", out_byte, 8'h11);
    @(posedge top_clk); #1;
    chk("t3_byte", {out_valid, out_byte}, {1'b1, 8'h22});
    @(posedge top_clk); #1;
    chk("t4_byte", {out_valid, out_byte}, {1'b1, 8'h33});
    drain("drain_lit");
    chk("count_lit", out_byte_count, 3);
    send(3'd0, {5{8'h5A}}, 3'd0, '0, 3'd0, '0, 1'b0);
    drain("drain_drop");
    chk("drop_no_overflow", out_err_overflow, 0);
    exp_q.push_back(DONE);
    send(3'd0, '0, 3'd0, '0, 3'd0, '0, 1'b1);
    drain("drain_last_only");
    chk("count_after_done", out_byte_count, 0);
    // flag 7 run and the zero-length run
    exp_q.push_back(9'hA0);
    repeat (4) exp_q.push_back(9'hFF);
    exp_q.push_back(9'hB4); exp_q.push_back(9'hB5);
    send(3'd7, {8'hB5, 8'hB4, 8'd4, 8'hFF, 8'hA0}, 3'd0, '0, 3'd0, '0, 1'b0);
    drain("drain_f7");
    chk("count_f7", out_byte_count, 7);
    exp_q.push_back(9'hA0); exp_q.push_back(9'hB4); exp_q.push_back(9'hB5);
    send(3'd7, {8'hB5, 8'hB4, 8'd0, 8'hFF, 8'hA0}, 3'd0, '0, 3'd0, '0, 1'b0);
    drain("drain_f7_zero");
    chk("count_f7_zero", out_byte_count, 10);
    exp_q.push_back(DONE);
    send(3'd0, '0, 3'd0, '0, 3'd0, '0, 1'b1);
    drain("drain_last2");
    chk("count_cleared", out_byte_count, 0);
    // three lanes in order, then a frame end
    exp_q.push_back(9'h11); exp_q.push_back(9'h21); exp_q.push_back(9'h22);
    exp_q.push_back(9'h31); exp_q.push_back(9'h32); exp_q.push_back(9'h32);
    exp_q.push_back(DONE);
    send(3'd1, {8'h15, 8'h14, 8'h13, 8'h12, 8'h11}, 3'd2, {8'h25, 8'h24, 8'h23, 8'h22, 8'h21},
         3'd5, {8'h35, 8'h34, 8'd2, 8'h32, 8'h31}, 1'b0);
    send(3'd0, '0, 3'd0, '0, 3'd0, '0, 1'b1);
    drain("drain_lanes");
    chk("count_lanes_done", out_byte_count, 0);
    chk("no_err_flag_yet", out_err_flag, 0);
    // flag 4 on lane 2
    exp_q.push_back(9'h41); exp_q.push_back(9'h61); exp_q.push_back(9'h62);
    send(3'd1, {8'h0, 8'h0, 8'h0, 8'h0, 8'h41}, 3'd4, {8'h55, 8'h54, 8'h53, 8'h52, 8'h51},
         3'd2, {8'h0, 8'h0, 8'h0, 8'h62, 8'h61}, 1'b0);
    drain("drain_f4");
    chk("err_flag_set", out_err_flag, 1);
    chk("count_f4", out_byte_count, 3);
    // stall mid-run while overfilling the FIFO
    exp_q.push_back(9'h70);
    repeat (3) exp_q.push_back(9'h77);
    exp_q.push_back(9'h74);
    for (int i = 0; i < 4; i++) exp_q.push_back(9'(8'h81 + i));
    out_ready = 1'b0;
    send(3'd6, {8'h00, 8'h74, 8'd3, 8'h77, 8'h70}, 3'd0, '0, 3'd0, '0, 1'b0);
    repeat (2) @(posedge top_clk);
    #1 chk("stall_head", out_byte, 8'h70);
    out_ready = 1'b1;
    repeat (2) @(posedge top_clk);
    #1 out_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(3'd1, {32'h0, 8'(8'h81 + i)}, 3'd0, '0, 3'd0, '0, 1'b0);
      chk($sformatf("ovf_in_ready_%0d", i), in_ready, i < 4 ? 1 : 0);
      chk($sformatf("stall_byte_%0d", i), {out_valid, out_byte}, {1'b1, 8'h77});
      @(posedge top_clk);
      #1;
    end
    in_valid = 1'b0;
    chk("overflow_set", out_err_overflow, 1);
    chk("stall_byte_end", out_byte, 8'h77);
    out_ready = 1'b1;
    drain("drain_stall");
    chk("count_stall", out_byte_count, 12);
    chk("err_flag_sticky", out_err_flag, 1);
    // reset in the middle of a long run with a queued entry behind it
    exp_q.push_back(9'h90);
    repeat (200) exp_q.push_back(9'h99);
    send(3'd5, {8'h00, 8'h00, 8'd200, 8'h99, 8'h90}, 3'd0, '0, 3'd0, '0, 1'b0);
    send(3'd1, {32'h0, 8'hAA}, 3'd0, '0, 3'd0, '0, 1'b0);
    repeat (8) @(posedge top_clk);
    #3 top_reset = 1'b1;
    exp_q.delete();
    #1;
    chk("mid_rst_valid", out_valid, 0);
    chk("mid_rst_in_ready", in_ready, 1);
    chk("mid_rst_count", out_byte_count, 0);
    chk("mid_rst_errs", {out_err_flag, out_err_overflow}, 0);
    @(posedge top_clk);
    #1 top_reset = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(posedge top_clk);
      #1 chk($sformatf("post_rst_empty_%0d", i), out_valid, 0);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1);
  end
endmodule
